riscv_gpr_file: RTL and testbench

- Parametrised general-purpose register file for the RISC-V core, superseding the read-only GPR block.
- Provides N combinational read ports, one synchronous write port, and hardwired-zero register 0.
- Provides optional write-to-read bypass.
- Includes a hardware clear sequencer that zeroes the array after reset or on request, so no simulation file load is needed.
- Sits between decode (read ports) and writeback (write port).

---
 rtl/riscv_gpr_file.sv | 104 ++++++++++
 tb/tb_riscv_gpr_file.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_gpr_file.sv
// RISC-V general-purpose register file: NUM_RD combinational read ports, one
// synchronous write port, hardwired x0, optional write bypass, hardware clear sweep.
module riscv_gpr_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  output logic                     wr_drop,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              ready_nxt;
  logic              wr_drop_nxt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem [DEPTH];

  // State, sweep counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ready   <= ready_nxt;
      wr_drop <= wr_drop_nxt;
    end
  end

  // Next state and array write port selection (sweep owns the port in CLEAR)
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready_nxt   = 1'b0;
    wr_drop_nxt = wr_en & ~ready;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (clear_req) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = RUN;
          ready_nxt   = 1'b1;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        mem_we = wr_en && (wr_addr != '0);
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Storage array; contents are initialised by the sweep, not by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Combinational read ports with x0, not-ready masking and optional bypass
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*XLEN +: XLEN] =
      ((ra == '0) || !ready)                           ? '0      :
      ((BYPASS != 0) && wr_en && (wr_addr == ra))      ? wr_data :
                                                         mem[ra];
  end

endmodule

// File: tb/tb_riscv_gpr_file.sv
// Directed self-checking bench for riscv_gpr_file: default, no-bypass and wide configurations.
module tb_riscv_gpr_file;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default configuration (XLEN=32, ADDR_W=5, NUM_RD=2, BYPASS=1)
  logic        clear_req, wr_en, ready, wr_drop;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;

  // BYPASS=0 configuration
  logic        nb_clear_req, nb_wr_en, nb_ready, nb_wr_drop;
  logic [4:0]  nb_wr_addr;
  logic [31:0] nb_wr_data;
  logic [9:0]  nb_rd_addr;
  logic [63:0] nb_rd_data;

  // Wide configuration (XLEN=64, ADDR_W=4, NUM_RD=3)
  logic         w_clear_req, w_wr_en, w_ready, w_wr_drop;
  logic [3:0]   w_wr_addr;
  logic [63:0]  w_wr_data;
  logic [11:0]  w_rd_addr;
  logic [191:0] w_rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_gpr_file u_dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  riscv_gpr_file #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .clear_req(nb_clear_req), .ready(nb_ready),
    .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data), .wr_drop(nb_wr_drop),
    .rd_addr(nb_rd_addr), .rd_data(nb_rd_data)
  );

  riscv_gpr_file #(.XLEN(64), .ADDR_W(4), .NUM_RD(3)) u_wide (
    .clk(clk), .rst_n(rst_n), .clear_req(w_clear_req), .ready(w_ready),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_drop(w_wr_drop),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data)
  );

  // Stimulus only: one write cycle on the default instance, ends on the next negedge
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int c_m, c_n, c_w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_chk++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop); end
    rst_n = 1'b1;
    c_m = -1; c_n = -1; c_w = -1;
    for (int c = 0; c < 100; c++) begin
      if (ready === 1'b1 && c_m < 0) c_m = c;
      if (nb_ready === 1'b1 && c_n < 0) c_n = c;
      if (w_ready === 1'b1 && c_w < 0) c_w = c;
      if (c_m >= 0 && c_n >= 0 && c_w >= 0) break;
      @(negedge clk);
    end
    n_chk++;
    if (c_m != 32) begin n_fail++; $display("FAIL sweep_len_main: got %0d expected 32", c_m); end
    n_chk++;
    if (c_n != 32) begin n_fail++; $display("FAIL sweep_len_nb: got %0d expected 32", c_n); end
    n_chk++;
    if (c_w != 16) begin n_fail++; $display("FAIL sweep_len_wide: got %0d expected 16", c_w); end
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      #1;
      n_chk++;
      if (rd_data !== 64'h0) begin
        n_fail++; $display("FAIL reset_zero x%0d: got %h expected 0", i, rd_data);
      end
    end
  endtask

  task automatic test_write_readback();
    do_write(5'd5, 32'hDEADBEEF);
    rd_addr = {5'd5, 5'd5};
    #1;
    n_chk++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rb_port0: got %h expected deadbeef", rd_data[31:0]);
    end
    n_chk++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rb_port1: got %h expected deadbeef", rd_data[63:32]);
    end
    @(negedge clk);
    do_write(5'd0, 32'h12345678);
    rd_addr = {5'd5, 5'd0};
    #1;
    n_chk++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_read: got %h expected 0", rd_data[31:0]);
    end
    n_chk++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL x0_wr_drop: got %b expected 0", wr_drop); end
    n_chk++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL x5_kept: got %h expected deadbeef", rd_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd0, 5'd7};
    nb_wr_en = 1'b1; nb_wr_addr = 5'd7; nb_wr_data = 32'hA5A5A5A5; nb_rd_addr = {5'd0, 5'd7};
    #1;
    n_chk++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected a5a5a5a5", rd_data[31:0]);
    end
    n_chk++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_x0_port: got %h expected 0", rd_data[63:32]);
    end
    n_chk++;
    if (nb_rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h expected 0", nb_rd_data[31:0]);
    end
    @(negedge clk);
    wr_en = 1'b0; nb_wr_en = 1'b0;
    #1;
    n_chk++;
    if (nb_rd_data[31:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL nobypass_next_cycle: got %h expected a5a5a5a5", nb_rd_data[31:0]);
    end
    n_chk++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_stored: got %h expected a5a5a5a5", rd_data[31:0]);
    end
  endtask

  task automatic test_clear_req();
    int cnt;
    @(negedge clk);
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
    rd_addr = {5'd31, 5'd1};
    #1;
    n_chk++;
    if (rd_data !== 64'h1F1F1F1F_01010101) begin
      n_fail++; $display("FAIL fill_readback: got %h expected 1f1f1f1f01010101", rd_data);
    end
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      if (cnt == 4) begin
        n_chk++;
        if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", wr_drop); end
        wr_en = 1'b0;
      end
      if (cnt == 5) begin
        n_chk++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL drop_single: got %b expected 0", wr_drop); end
      end
      if (cnt == 3) begin wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFEF00D; end
      cnt++;
      @(negedge clk);
    end
    n_chk++;
    if (cnt != 32) begin n_fail++; $display("FAIL clear_len: got %0d expected 32", cnt); end
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'(32 - i), 5'(i)};
      #1;
      n_chk++;
      if (rd_data !== 64'h0) begin
        n_fail++; $display("FAIL cleared x%0d: got %h expected 0", i, rd_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    // Reset during an active write in RUN
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF0000;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_write_ready: got %b expected 0", ready); end
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_chk++;
    if (cnt != 32) begin n_fail++; $display("FAIL mid_write_sweep: got %0d expected 32", cnt); end
    rd_addr = {5'd9, 5'd9};
    #1;
    n_chk++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_write_x9: got %h expected 0", rd_data); end
    // Reset at cycle 10 of a clear sweep
    do_write(5'd9, 32'hFFFF0000);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (10) @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF0000;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_ready: got %b expected 0", ready); end
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_drop: got %b expected 0", wr_drop); end
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_chk++;
    if (cnt != 32) begin n_fail++; $display("FAIL mid_sweep_len: got %0d expected 32", cnt); end
    #1;
    n_chk++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_sweep_x9: got %h expected 0", rd_data); end
  endtask

  task automatic test_param_sweep();
    int cnt;
    cnt = 0;
    while (w_ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_chk++;
    if (w_ready !== 1'b1) begin n_fail++; $display("FAIL wide_ready: got %b expected 1", w_ready); end
    w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 64'h0123456789ABCDEF;
    @(negedge clk);
    w_wr_en = 1'b0;
    w_rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (w_rd_data[k*64 +: 64] !== 64'h0123456789ABCDEF) begin
        n_fail++; $display("FAIL wide_port%0d: got %h expected 0123456789abcdef", k, w_rd_data[k*64 +: 64]);
      end
    end
    w_rd_addr = {4'd0, 4'd14, 4'd15};
    #1;
    n_chk++;
    if (w_rd_data !== {64'h0, 64'h0, 64'h0123456789ABCDEF}) begin
      n_fail++; $display("FAIL wide_mixed: got %h expected 0/0/0123456789abcdef", w_rd_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    nb_clear_req = 1'b0; nb_wr_en = 1'b0; nb_wr_addr = '0; nb_wr_data = '0; nb_rd_addr = '0;
    w_clear_req = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;
    test_reset();
    test_write_readback();
    test_bypass();
    test_clear_req();
    test_reset_mid();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
